// File: rtl/alu_imm_pc_unit_if.sv
// Bundle of the decode/execute signals seen by alu_imm_pc_unit.
// master: drives load enable, instruction, pc, operands and ALU select; observes results.
// slave : the unit itself; consumes the inputs and drives the registered results.
//   en          load enable for the output registers
//   instr[31:0] instruction word (opcode [31:26], immediate [15:0])
//   pc[31:0]    program counter
//   srca, srcb  ALU operands
//   alu_control ALU operation select
//   alu_out     registered ALU result
//   zero        registered "result was zero" flag
//   imm_ext     registered extended immediate
//   pc_plus4    registered pc + increment
interface alu_imm_pc_unit_if;
   logic        en;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] srca;
   logic [31:0] srcb;
   logic [2:0]  alu_control;
   logic [31:0] alu_out;
   logic        zero;
   logic [31:0] imm_ext;
   logic [31:0] pc_plus4;

   modport master (
      output en, instr, pc, srca, srcb, alu_control,
      input  alu_out, zero, imm_ext, pc_plus4
   );

   modport slave (
      input  en, instr, pc, srca, srcb, alu_control,
      output alu_out, zero, imm_ext, pc_plus4
   );
endinterface

// File: rtl/alu_imm_pc_unit.sv
// Registered ALU, immediate extender and pc incrementer.
// All three results are computed combinationally and captured together on the rising
// clock edge when en is high, giving one cycle of latency. Synchronous active-high reset
// clears the results (zero flag set) and overrides en.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    alu_imm_pc_unit_if slave modport (inputs and registered results)
module alu_imm_pc_unit #(
   parameter logic [31:0] PC_INC = 32'd4
) (
   input logic                clk,
   input logic                reset,
   alu_imm_pc_unit_if.slave   bus
);

   localparam logic [5:0] OpAndi = 6'h0C;
   localparam logic [5:0] OpOri  = 6'h0D;
   localparam logic [5:0] OpXori = 6'h0E;
   localparam logic [5:0] OpLui  = 6'h0F;

   logic [31:0] alu_d;
   logic [31:0] imm_d;
   logic [31:0] pc_inc_d;
   logic        zero_d;

   logic [31:0] alu_q;
   logic [31:0] imm_q;
   logic [31:0] pc_inc_q;
   logic        zero_q;

   logic [5:0]  opcode;
   logic [15:0] imm16;

   assign opcode = bus.instr[31:26];
   assign imm16  = bus.instr[15:0];

   always_comb begin
      alu_d = 32'h0;
      unique case (bus.alu_control)
         3'b000: alu_d = bus.srca & bus.srcb;
         3'b001: alu_d = bus.srca | bus.srcb;
         3'b010: alu_d = bus.srca + bus.srcb;
         3'b011: alu_d = bus.srca ^ bus.srcb;
         3'b100: alu_d = ~(bus.srca | bus.srcb);
         3'b101: alu_d = bus.srca << bus.srcb[4:0];
         3'b110: alu_d = bus.srca - bus.srcb;
         3'b111: alu_d = {31'h0, $signed(bus.srca) < $signed(bus.srcb)};
         default: alu_d = 32'h0;
      endcase
   end

   assign zero_d = (alu_d == 32'h0);

   always_comb begin
      imm_d = {{16{imm16[15]}}, imm16};
      unique case (opcode)
         OpAndi, OpOri, OpXori: imm_d = {16'h0, imm16};
         OpLui:                 imm_d = {imm16, 16'h0};
         default:               imm_d = {{16{imm16[15]}}, imm16};
      endcase
   end

   assign pc_inc_d = bus.pc + PC_INC;

   always_ff @(posedge clk) begin
      if (reset) begin
         alu_q    <= 32'h0;
         zero_q   <= 1'b1;
         imm_q    <= 32'h0;
         pc_inc_q <= 32'h0;
      end else if (bus.en) begin
         alu_q    <= alu_d;
         zero_q   <= zero_d;
         imm_q    <= imm_d;
         pc_inc_q <= pc_inc_d;
      end
   end

   assign bus.alu_out  = alu_q;
   assign bus.zero     = zero_q;
   assign bus.imm_ext  = imm_q;
   assign bus.pc_plus4 = pc_inc_q;

endmodule

// File: tb/tb_alu_imm_pc_unit.sv
// Directed bench for alu_imm_pc_unit: reset, ALU sweep, signed boundaries, immediate
// extension, pc increment and hold behaviour, with hand-computed expectations.
module tb_alu_imm_pc_unit;

   logic clk;
   logic reset;
   int   n_asserts;
   int   n_fail;

   alu_imm_pc_unit_if bus ();

   alu_imm_pc_unit #(
      .PC_INC (32'd4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past the next rising edge; outputs are then stable for sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic [31:0] ins, input logic [31:0] p);
      bus.srca        = a;
      bus.srcb        = b;
      bus.alu_control = op;
      bus.instr       = ins;
      bus.pc          = p;
   endtask

   logic [31:0] sweep_exp [8];

   initial begin
      n_asserts = 0;
      n_fail    = 0;
      sweep_exp[0] = 32'h00000003;
      sweep_exp[1] = 32'h0000000F;
      sweep_exp[2] = 32'h00000012;
      sweep_exp[3] = 32'h0000000C;
      sweep_exp[4] = 32'hFFFFFFF0;
      sweep_exp[5] = 32'h00000078;
      sweep_exp[6] = 32'h0000000C;
      sweep_exp[7] = 32'h00000000;

      // Reset with en=1 and arbitrary inputs.
      reset  = 1'b1;
      bus.en = 1'b1;
      drive(32'h12345678, 32'h9ABCDEF0, 3'b010, 32'h8C00FFF8, 32'h00400000);
      step();
      check("rst_alu", bus.alu_out, 32'h0);
      check("rst_zero", {31'h0, bus.zero}, 32'h1);
      check("rst_imm", bus.imm_ext, 32'h0);
      check("rst_pc", bus.pc_plus4, 32'h0);

      // First enabled edge after reset captures immediately.
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(32'h0000000F, 32'h00000003, 3'(i), 32'h00000000, 32'h00000000);
         step();
         check($sformatf("sweep_alu_%0d", i), bus.alu_out, sweep_exp[i]);
         check($sformatf("sweep_zero_%0d", i), {31'h0, bus.zero},
               (i == 7) ? 32'h1 : 32'h0);
      end

      // Signed boundaries.
      drive(32'hFFFFFFFF, 32'h00000001, 3'b111, 32'h0, 32'h0);
      step();
      check("slt_neg", bus.alu_out, 32'h1);
      drive(32'h00000001, 32'hFFFFFFFF, 3'b111, 32'h0, 32'h0);
      step();
      check("slt_pos", bus.alu_out, 32'h0);
      drive(32'h00000005, 32'h00000005, 3'b110, 32'h0, 32'h0);
      step();
      check("sub_eq", bus.alu_out, 32'h0);
      check("sub_eq_zero", {31'h0, bus.zero}, 32'h1);
      drive(32'h80000000, 32'h00000001, 3'b110, 32'h0, 32'h0);
      step();
      check("sub_wrap", bus.alu_out, 32'h7FFFFFFF);
      check("sub_wrap_zero", {31'h0, bus.zero}, 32'h0);
      drive(32'hFFFFFFFF, 32'h00000001, 3'b010, 32'h0, 32'h0);
      step();
      check("add_wrap", bus.alu_out, 32'h0);

      // Immediate extension.
      drive(32'h0, 32'h0, 3'b000, 32'h8C00FFF8, 32'h0);
      step();
      check("imm_lw", bus.imm_ext, 32'hFFFFFFF8);
      drive(32'h0, 32'h0, 3'b000, 32'h3400FFF8, 32'h0);
      step();
      check("imm_ori", bus.imm_ext, 32'h0000FFF8);
      drive(32'h0, 32'h0, 3'b000, 32'h3000FFF8, 32'h0);
      step();
      check("imm_andi", bus.imm_ext, 32'h0000FFF8);
      drive(32'h0, 32'h0, 3'b000, 32'h3800FFF8, 32'h0);
      step();
      check("imm_xori", bus.imm_ext, 32'h0000FFF8);
      drive(32'h0, 32'h0, 3'b000, 32'h3C001234, 32'h0);
      step();
      check("imm_lui", bus.imm_ext, 32'h12340000);
      drive(32'h0, 32'h0, 3'b000, 32'h20007FFF, 32'h0);
      step();
      check("imm_pos", bus.imm_ext, 32'h00007FFF);

      // PC increment.
      drive(32'h0, 32'h0, 3'b000, 32'h0, 32'h00400000);
      step();
      check("pc_norm", bus.pc_plus4, 32'h00400004);
      drive(32'h0, 32'h0, 3'b000, 32'h0, 32'hFFFFFFFC);
      step();
      check("pc_wrap", bus.pc_plus4, 32'h00000000);

      // Hold: capture, then en=0 with changed inputs for three edges.
      drive(32'h0000000F, 32'h00000003, 3'b010, 32'h8C00FFF8, 32'h00000100);
      step();
      bus.en = 1'b0;
      drive(32'h00000001, 32'h00000001, 3'b110, 32'h3C001234, 32'h00000200);
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("hold_alu_%0d", i), bus.alu_out, 32'h00000012);
         check($sformatf("hold_zero_%0d", i), {31'h0, bus.zero}, 32'h0);
         check($sformatf("hold_imm_%0d", i), bus.imm_ext, 32'hFFFFFFF8);
         check($sformatf("hold_pc_%0d", i), bus.pc_plus4, 32'h00000104);
      end
      bus.en = 1'b1;
      step();
      check("resume_alu", bus.alu_out, 32'h0);
      check("resume_zero", {31'h0, bus.zero}, 32'h1);
      check("resume_imm", bus.imm_ext, 32'h12340000);
      check("resume_pc", bus.pc_plus4, 32'h00000204);

      // Reset overrides en after non-zero state.
      drive(32'h0000000F, 32'h00000003, 3'b001, 32'h8C00FFF8, 32'h00000100);
      step();
      check("pre_rst_alu", bus.alu_out, 32'h0000000F);
      reset = 1'b1;
      step();
      check("rst2_alu", bus.alu_out, 32'h0);
      check("rst2_zero", {31'h0, bus.zero}, 32'h1);
      check("rst2_imm", bus.imm_ext, 32'h0);
      check("rst2_pc", bus.pc_plus4, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_imm_pc_unit.md
ALU_IMM_PC_UNIT -- requirements
Module: alu_imm_pc_unit

Interface
REQ-001 SHALL have parameter PC_INC, default 4, meaning the constant added to pc.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port reset, input, 1, reset; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port en, input, 1, output-register load enable.
REQ-005 SHALL have port instr, input, 32, decode-stage instruction word; opcode is [31:26], immediate is [15:0].
REQ-006 SHALL have port pc, input, 32, fetch-stage program counter.
REQ-007 SHALL have port srca, input, 32, ALU operand A.
REQ-008 SHALL have port srcb, input, 32, ALU operand B.
REQ-009 SHALL have port alu_control, input, 3, ALU operation select.
REQ-010 SHALL have port alu_out, output, 32, registered ALU result.
REQ-011 SHALL have port zero, output, 1, registered flag, 1 when the ALU result is 0.
REQ-012 SHALL have port imm_ext, output, 32, registered extended immediate.
REQ-013 SHALL have port pc_plus4, output, 32, registered pc + PC_INC.

Function
REQ-014 All three datapaths SHALL be computed combinationally from the current inputs and captured into the output registers on the rising clk edge when en=1.
REQ-015 Latency SHALL be exactly 1 cycle: outputs reflect the inputs sampled at the previous enabled edge.
REQ-016 With en=0 and reset=0, all outputs SHALL hold their values.
REQ-017 ALU encoding SHALL be:
- 000: AND
- 001: OR
- 010: ADD
- 011: XOR
- 100: NOR
- 101: SLL, srca << srcb[4:0]
- 110: SUB, srca - srcb
- 111: SLT
REQ-018 SLT SHALL perform a signed two's-complement compare and produce 32'h1 if srca < srcb, else 32'h0.
REQ-019 ADD and SUB SHALL wrap modulo 2^32 with no overflow or carry output.
REQ-020 zero SHALL be 1 if and only if the 32-bit ALU result captured in the same edge equals 0.
REQ-021 Immediate extension SHALL be selected by instr[31:26]:
- 0x0C (andi), 0x0D (ori), 0x0E (xori): zero-extend instr[15:0].
- 0x0F (lui): {instr[15:0], 16'h0}.
- All other opcodes: sign-extend instr[15:0] by replicating bit 15.
REQ-022 pc_plus4 SHALL equal pc + PC_INC modulo 2^32, so 32'hFFFFFFFC yields 32'h0.
REQ-023 Outputs SHALL contain no X when all inputs are known, including every alu_control code.

Reset
REQ-024 On a rising clk edge with reset=1, alu_out, imm_ext and pc_plus4 SHALL become 32'h0 and zero SHALL become 1.
REQ-025 reset SHALL take priority over en.
REQ-026 Reset SHALL have no asynchronous effect; outputs change only on clk edges.
REQ-027 On the first enabled edge after reset deasserts, normal capture SHALL resume with no extra delay.

Verification
REQ-028 Reset: reset=1, en=1 with arbitrary inputs for one edge -> alu_out=0, zero=1, imm_ext=0, pc_plus4=0.
REQ-029 ALU sweep: srca=32'h0000000F, srcb=32'h00000003, codes 000..111 -> respectively 3, F, 12, C, FFFFFFF0, 78, C, 0.
REQ-030 Signed SLT and SUB boundaries:
- srca=32'hFFFFFFFF, srcb=1, code 111 -> 1.
- srca=5, srcb=5, code 110 -> 0 and zero=1.
- srca=32'h80000000, srcb=1, code 110 -> 32'h7FFFFFFF.
REQ-031 Immediate extension, each one edge later:
- instr=32'h8C00FFF8 (lw) -> imm_ext=32'hFFFFFFF8.
- instr=32'h3400FFF8 (ori) -> imm_ext=32'h0000FFF8.
- instr=32'h3C001234 (lui) -> imm_ext=32'h12340000.
REQ-032 PC increment: pc=32'h00400000 -> pc_plus4=32'h00400004; pc=32'hFFFFFFFC -> pc_plus4=32'h0.
REQ-033 Hold: capture one result, then en=0 while all inputs change for 3 edges -> outputs unchanged; en=1 -> new values appear after 1 edge.
